// File: rtl/load_store_ctrl.sv
// Purpose : sequences LDR/STR uOPs onto the D-Cache (words 0..30) or the GPIO port (addr 31) and returns load data to the register file.
// Latency : GPIO LDR writeback 2 cycles after accept; GPIO STR strobe 1 cycle after accept; D-Cache ops 1 cycle after dc_ack.
// Backpres: req_ready is low while an op is in flight; dc_req is held until dc_ack or TIMEOUT unacked cycles.
//
// Ports:
//   clk, rst                     clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready          uOP handshake; uop/addr/st_data/rd are captured on accept
//   dc_req/dc_we/dc_addr/dc_wdata D-Cache request, held stable until dc_ack
//   dc_ack/dc_rdata              D-Cache completion and read data (same cycle)
//   gpio_we/gpio_wdata           one-cycle GPIO write strobe and data
//   gpio_state                   GPIO pin state, sampled by GPIO loads
//   wb_valid/wb_rd/wb_data       one-cycle register file write strobe
//   fault                        one-cycle pulse on undefined address or D-Cache timeout
module load_store_ctrl #(
   parameter logic [4:0] UOP_LDR   = 5'd10,
   parameter logic [4:0] UOP_STR   = 5'd11,
   parameter int         GPIO_ADDR = 31,
   parameter int         TIMEOUT   = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [4:0]  uop,
   input  logic [31:0] addr,
   input  logic [31:0] st_data,
   input  logic [3:0]  rd,
   output logic        dc_req,
   output logic        dc_we,
   output logic [4:0]  dc_addr,
   output logic [31:0] dc_wdata,
   input  logic        dc_ack,
   input  logic [31:0] dc_rdata,
   output logic        gpio_we,
   output logic [31:0] gpio_wdata,
   input  logic [31:0] gpio_state,
   output logic        wb_valid,
   output logic [3:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        fault
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_DC_WAIT = 2'd1;
   localparam logic [1:0] S_GPIO    = 2'd2;
   localparam logic [1:0] S_WB      = 2'd3;

   localparam logic [31:0] GPIO_A = 32'(GPIO_ADDR);
   // Counter only has to reach TIMEOUT-1; the last unacked cycle ends the wait.
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   // Everything the op needs after the accept cycle.
   typedef struct packed {
      logic        is_ldr;
      logic [4:0]  idx;
      logic [31:0] data;
      logic [3:0]  rd;
   } lat_t;

   logic [1:0]    state;
   lat_t          lat;
   logic [CW-1:0] to_cnt;
   logic [31:0]   wb_data_q;
   logic          fault_q;

   logic accept;
   logic is_ldr_in;
   logic to_dc;
   logic to_gpio;
   logic timed_out;

   assign is_ldr_in = (uop == UOP_LDR);
   assign accept    = req_valid && (state == S_IDLE) && (is_ldr_in || (uop == UOP_STR));
   assign to_dc     = (addr < GPIO_A);
   assign to_gpio   = (addr == GPIO_A);
   // An ack in the expiring cycle takes priority, so it masks the timeout here.
   assign timed_out = (TIMEOUT != 0) && !dc_ack && (to_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         lat       <= '0;
         to_cnt    <= '0;
         wb_data_q <= '0;
         fault_q   <= 1'b0;
      end else begin
         fault_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  lat    <= '{is_ldr: is_ldr_in, idx: addr[4:0], data: st_data, rd: rd};
                  to_cnt <= '0;
                  if (to_dc) begin
                     state <= S_DC_WAIT;
                  end else if (to_gpio) begin
                     state <= S_GPIO;
                  end else begin
                     // Undefined address: loads write back zero alongside the fault,
                     // stores only raise the fault and never touch a resource.
                     fault_q <= 1'b1;
                     if (is_ldr_in) begin
                        wb_data_q <= '0;
                        state     <= S_WB;
                     end
                  end
               end
            end
            S_DC_WAIT: begin
               if (dc_ack) begin
                  if (lat.is_ldr) begin
                     wb_data_q <= dc_rdata;
                     state     <= S_WB;
                  end else begin
                     state <= S_IDLE;
                  end
               end else if (timed_out) begin
                  fault_q <= 1'b1;
                  if (lat.is_ldr) begin
                     wb_data_q <= '0;
                     state     <= S_WB;
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  to_cnt <= to_cnt + CW'(1);
               end
            end
            S_GPIO: begin
               if (lat.is_ldr) begin
                  wb_data_q <= gpio_state;
                  state     <= S_WB;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_WB: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Strobes decode straight from the state so they are mutually exclusive
   // and drop the instant reset is asserted.
   assign req_ready  = (state == S_IDLE);
   assign dc_req     = (state == S_DC_WAIT);
   assign dc_we      = dc_req && !lat.is_ldr;
   assign dc_addr    = lat.idx;
   assign dc_wdata   = lat.data;
   assign gpio_we    = (state == S_GPIO) && !lat.is_ldr;
   assign gpio_wdata = lat.data;
   assign wb_valid   = (state == S_WB);
   assign wb_rd      = lat.rd;
   assign wb_data    = wb_data_q;
   assign fault      = fault_q;

endmodule
